obi_copy_master: RTL and testbench
==================================

// Module: obi_copy_master
// PURPOSE
//  OBI initiator that copies a block of 32-bit words from a source address to a destination address.
//  Drives one OBI data port in the same format the SRAM wrapper's sram_d port accepts (req/gnt/rvalid).
//  Sits beside the core on the data-side mux as a second bus master; software starts it through the start/len/src/dst ports.
//  At most one outstanding transaction; reads and writes strictly alternate.
// PARAMETERS
//  LEN_W      16  width of word-count field; max copy = 2**LEN_W-1 words
//  ADDR_W     32  OBI address width
// PORTS
//  clk_i             in   1       clock, all logic on posedge
//  rst_i             in   1       synchronous, active-high reset
//  start_i           in   1       1-cycle pulse: latch src/dst/len, begin copy (ignored when busy_o=1)
//  src_addr_i        in   ADDR_W  source byte address; [1:0] ignored (forced 0)
//  dst_addr_i        in   ADDR_W  destination byte address; [1:0] ignored (forced 0)
//  len_i             in   LEN_W   number of words to copy
//  busy_o            out  1       1 from the cycle after start until done_o/err_o cycle inclusive
//  done_o            out  1       1-cycle pulse: copy completed successfully
//  err_o             out  1       1-cycle pulse: copy aborted on illegal_memory_i
//  obi_req_o         out  1       OBI request
//  obi_gnt_i         in   1       OBI grant
//  obi_addr_o        out  ADDR_W  OBI address
//  obi_we_o          out  1       1=write, 0=read
//  obi_be_o          out  4       byte enables; always 4'hF
//  obi_wdata_o       out  32      write data (word captured by the preceding read)
//  obi_rvalid_i      in   1       OBI response valid
//  obi_rdata_i       in   32      OBI read data
//  illegal_memory_i  in   1       responder error flag, sampled while obi_req_o=1
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except obi_be_o=4'hF; counters and address registers cleared.
//  FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH, ABORT.
//   IDLE    : start_i & len_i!=0 -> RD_REQ; start_i & len_i==0 -> FINISH.
//   RD_REQ  : req=1, we=0, addr=src. illegal_memory_i -> ABORT. Else gnt -> RD_WAIT.
//   RD_WAIT : req=0. rvalid -> capture rdata into wdata register -> WR_REQ.
//   WR_REQ  : req=1, we=1, addr=dst. illegal_memory_i -> ABORT. Else gnt -> WR_WAIT.
//   WR_WAIT : req=0. rvalid -> src+=4, dst+=4, remaining-=1; remaining==1 -> FINISH, else -> RD_REQ.
//   FINISH  : done_o=1 for one cycle -> IDLE.   ABORT: err_o=1 for one cycle -> IDLE.
//  OBI rule: while req=1 and gnt=0, addr/we/be/wdata must not change. req never drops before gnt, except on ABORT or reset.
//  rvalid arriving in a *_REQ state, or in IDLE, is ignored; rdata is captured only in RD_WAIT.
//  Grants the same cycle as req (SRAM responder behaviour): 4 cycles per word.
//   start in cycle 0 -> first req in cycle 1 -> done_o in cycle 4*len+1; len=0 -> done_o in cycle 1.
//  Address arithmetic: 32-bit wrap-around modulo 2**ADDR_W, no error on wrap.
//  Overlapping src/dst regions are copied in ascending order with no hazard protection.
//  rst_i asserted mid-copy: at the next edge, state returns to IDLE, req drops, and no done_o/err_o pulse is produced.
//   An rvalid still in flight after reset is ignored.
//  start_i while busy_o=1: ignored; latched src/dst/len unchanged.
// STRUCTURE
//  Package obi_copy_pkg: typedef enum logic [2:0] copy_state_e; localparam OBI_BE_FULL=4'hF; localparam WORD_BYTES=4.
//  Single module; no sub-module.
//  One always_ff holds state, address, count and wdata registers; one always_comb holds next-state and OBI output decode.
// TESTING
//  1 Copy len=4 src=0x8000_0000 dst=0x8000_0100 into an SRAM-model responder (gnt=req, rvalid +1 cycle)
//    -> dst words equal src words; done_o in cycle 17; 8 transactions total.
//  2 Same copy with gnt delayed 0..3 random cycles
//    -> addr/we/wdata stable while req&!gnt; data correct; one done_o pulse.
//  3 len=0 -> no obi_req_o; done_o in cycle 1; busy_o high for exactly 1 cycle.
//  4 src=0x0000_0000 (outside SRAM), responder raises illegal_memory_i
//    -> err_o pulse next cycle; no write issued; FSM back in IDLE.
//  5 rst_i asserted in WR_WAIT of word 2 of a len=4 copy
//    -> next cycle req=0, busy_o=0, no done_o; a new start afterwards completes correctly.
//  6 Second start_i pulse with different src while busy
//    -> ignored; copy completes with the original parameters.

Source files
------------

// File: rtl/obi_copy_pkg.sv
// Shared types and constants for the OBI block-copy initiator.
package obi_copy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FINISH,
        ABORT
    } copy_state_e;

    localparam logic [3:0] OBI_BE_FULL = 4'hF;
    localparam int         WORD_BYTES  = 4;

endpackage

// File: rtl/obi_copy_master.sv
// OBI initiator copying a block of 32-bit words from src to dst, one outstanding
// transaction at a time, reads and writes strictly alternating.
module obi_copy_master
    import obi_copy_pkg::*;
#(
    parameter int LEN_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              obi_req_o,
    input  logic              obi_gnt_i,
    output logic [ADDR_W-1:0] obi_addr_o,
    output logic              obi_we_o,
    output logic [3:0]        obi_be_o,
    output logic [31:0]       obi_wdata_o,
    input  logic              obi_rvalid_i,
    input  logic [31:0]       obi_rdata_i,
    input  logic              illegal_memory_i
);

    copy_state_e       state_q, state_d;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  rem_q;
    logic [31:0]       wdata_q;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        src_q <= {src_addr_i[ADDR_W-1:2], 2'b00};
                        dst_q <= {dst_addr_i[ADDR_W-1:2], 2'b00};
                        rem_q <= len_i;
                    end
                end
                RD_WAIT: begin
                    if (obi_rvalid_i) wdata_q <= obi_rdata_i;
                end
                WR_WAIT: begin
                    // Pointers advance only once the write is acknowledged.
                    if (obi_rvalid_i) begin
                        src_q <= src_q + ADDR_W'(WORD_BYTES);
                        dst_q <= dst_q + ADDR_W'(WORD_BYTES);
                        rem_q <= rem_q - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        obi_req_o  = 1'b0;
        obi_we_o   = 1'b0;
        obi_addr_o = src_q;
        done_o     = 1'b0;
        err_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = (len_i != '0) ? RD_REQ : FINISH;
            end
            RD_REQ: begin
                obi_req_o = 1'b1;
                if (illegal_memory_i) state_d = ABORT;
                else if (obi_gnt_i)   state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (obi_rvalid_i) state_d = WR_REQ;
            end
            WR_REQ: begin
                obi_req_o  = 1'b1;
                obi_we_o   = 1'b1;
                obi_addr_o = dst_q;
                if (illegal_memory_i) state_d = ABORT;
                else if (obi_gnt_i)   state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (obi_rvalid_i) state_d = (rem_q == LEN_W'(1)) ? FINISH : RD_REQ;
            end
            FINISH: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            ABORT: begin
                err_o   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o      = (state_q != IDLE);
    assign obi_be_o    = OBI_BE_FULL;
    assign obi_wdata_o = wdata_q;

endmodule

// File: tb/tb_obi_copy_master.sv
// Self-checking bench for obi_copy_master against an SRAM-like responder and a
// word-level copy model of the expected memory contents.
module tb_obi_copy_master;

    typedef logic [31:0] mem_t [logic [31:0]];
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, err_o, obi_req_o, obi_gnt_i, obi_we_o, illegal_memory_i;
    logic [31:0] obi_addr_o, obi_wdata_o;
    logic [3:0]  obi_be_o;
    logic        obi_rvalid_i = 1'b0;
    logic [31:0] obi_rdata_i = '0;

    int   total = 0;
    int   bad = 0;
    mem_t mem;
    mem_t exp_mem;
    txn_t txq[$];
    txn_t acc_txn;
    int   max_delay = 0;
    int   gnt_wait = 0;
    logic illegal_en = 1'b1;
    int   stab_err = 0;
    int   req_seen = 0;
    logic        prev_stall = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    obi_copy_master #(.LEN_W(16), .ADDR_W(32)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .src_addr_i       (src_addr_i),
        .dst_addr_i       (dst_addr_i),
        .len_i            (len_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .obi_req_o        (obi_req_o),
        .obi_gnt_i        (obi_gnt_i),
        .obi_addr_o       (obi_addr_o),
        .obi_we_o         (obi_we_o),
        .obi_be_o         (obi_be_o),
        .obi_wdata_o      (obi_wdata_o),
        .obi_rvalid_i     (obi_rvalid_i),
        .obi_rdata_i      (obi_rdata_i),
        .illegal_memory_i (illegal_memory_i)
    );

    always #5 clk_i = ~clk_i;

    // Responder: grants after gnt_wait stalled cycles, answers one cycle after grant.
    assign obi_gnt_i        = obi_req_o && (gnt_wait == 0);
    assign illegal_memory_i = obi_req_o && illegal_en && !obi_addr_o[31];

    always @(posedge clk_i) begin
        if (obi_req_o && obi_gnt_i && !illegal_memory_i) begin
            acc_txn.we    = obi_we_o;
            acc_txn.addr  = obi_addr_o;
            acc_txn.wdata = obi_wdata_o;
            txq.push_back(acc_txn);
            if (obi_we_o) begin
                mem[obi_addr_o] = obi_wdata_o;
                obi_rdata_i <= $urandom;
            end else begin
                obi_rdata_i <= mem.exists(obi_addr_o) ? mem[obi_addr_o] : 32'hDEAD_BEEF;
            end
            obi_rvalid_i <= 1'b1;
        end else begin
            obi_rvalid_i <= 1'b0;
            obi_rdata_i  <= $urandom;
        end
        if (!obi_req_o)      gnt_wait <= $urandom_range(max_delay, 0);
        else if (!obi_gnt_i) gnt_wait <= gnt_wait - 1;
    end

    // Bus-rule monitor: a stalled request must hold its attributes.
    always @(negedge clk_i) begin
        if (prev_stall && !rst_i) begin
            if (!obi_req_o || obi_addr_o !== prev_addr || obi_we_o !== prev_we ||
                obi_wdata_o !== prev_wdata)
                stab_err++;
        end
        if (obi_req_o) req_seen++;
        prev_stall = obi_req_o && !obi_gnt_i;
        prev_addr  = obi_addr_o;
        prev_we    = obi_we_o;
        prev_wdata = obi_wdata_o;
    end

    task automatic fill(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) mem[base + 32'(4 * i)] = $urandom;
    endtask

    // Word-by-word ascending copy applied to exp_mem.
    task automatic apply_model(input logic [31:0] s, input logic [31:0] d, input int len);
        logic [31:0] sa, da, ra;
        sa = {s[31:2], 2'b00};
        da = {d[31:2], 2'b00};
        for (int i = 0; i < len; i++) begin
            ra = sa + 32'(4 * i);
            exp_mem[da + 32'(4 * i)] = exp_mem.exists(ra) ? exp_mem[ra] : 32'hDEAD_BEEF;
        end
    endtask

    function automatic int mem_diff();
        int n = 0;
        if (mem.num() != exp_mem.num()) n++;
        foreach (exp_mem[k]) if (!mem.exists(k) || mem[k] !== exp_mem[k]) n++;
        return n;
    endfunction

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int len);
        @(negedge clk_i);
        start_i = 1'b1;
        src_addr_i = s;
        dst_addr_i = d;
        len_i = 16'(len);
        @(negedge clk_i);
        start_i = 1'b0;
        src_addr_i = $urandom;
        dst_addr_i = $urandom;
        len_i = 16'($urandom);
    endtask

    // Called at the falling edge of cycle 1 (start was sampled at the end of cycle 0).
    task automatic observe(input int budget, input int re_cyc, input logic [31:0] re_src,
                           input logic [31:0] re_dst, input int re_len,
                           output int done_cyc, output int err_cyc, output int n_done,
                           output int n_err, output int n_busy);
        done_cyc = -1; err_cyc = -1; n_done = 0; n_err = 0; n_busy = 0;
        for (int c = 1; c <= budget; c++) begin
            if (c > 1) @(negedge clk_i);
            if (re_cyc != 0 && c == re_cyc) begin
                start_i = 1'b1;
                src_addr_i = re_src;
                dst_addr_i = re_dst;
                len_i = 16'(re_len);
            end else begin
                start_i = 1'b0;
            end
            if (done_o) begin n_done++; if (done_cyc < 0) done_cyc = c; end
            if (err_o)  begin n_err++;  if (err_cyc < 0)  err_cyc = c;  end
            if (busy_o) n_busy++;
            if (done_cyc > 0 && c >= done_cyc + 3) break;
            if (err_cyc > 0 && c >= err_cyc + 3) break;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        total += 6;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        if (done_o !== 1'b0 || err_o !== 1'b0) begin
            bad++; $display("FAIL reset_pulses: got done=%b err=%b want 0 0", done_o, err_o);
        end
        if (obi_req_o !== 1'b0 || obi_we_o !== 1'b0) begin
            bad++; $display("FAIL reset_req_we: got %b %b want 0 0", obi_req_o, obi_we_o);
        end
        if (obi_be_o !== 4'hF) begin bad++; $display("FAIL reset_be: got %h want f", obi_be_o); end
        if (obi_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", obi_addr_o); end
        if (obi_wdata_o !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", obi_wdata_o); end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_basic_copy();
        logic [31:0] s = 32'h8000_0000, d = 32'h8000_0100, ea;
        int dc, ec, nd, ne, nb;
        mem_t orig;
        txq.delete();
        orig = mem;
        exp_mem = mem;
        apply_model(s, d, 4);
        do_start(s, d, 4);
        observe(100, 0, 0, 0, 0, dc, ec, nd, ne, nb);
        total += 6;
        if (dc !== 17) begin bad++; $display("FAIL basic_done_cycle: got %0d want 17", dc); end
        if (nd !== 1 || ne !== 0) begin bad++; $display("FAIL basic_pulses: got done=%0d err=%0d want 1 0", nd, ne); end
        if (nb !== 17) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 17", nb); end
        if (txq.size() !== 8) begin bad++; $display("FAIL basic_txn_count: got %0d want 8", txq.size()); end
        if (mem_diff() !== 0) begin bad++; $display("FAIL basic_mem: got %0d differing words want 0", mem_diff()); end
        if (obi_be_o !== 4'hF) begin bad++; $display("FAIL basic_be: got %h want f", obi_be_o); end
        for (int i = 0; i < txq.size(); i++) begin
            ea = ((i % 2) ? d : s) + 32'(4 * (i / 2));
            total++;
            if (txq[i].we !== logic'(i % 2) || txq[i].addr !== ea) begin
                bad++;
                $display("FAIL basic_txn%0d: got we=%b addr=%h want we=%0d addr=%h",
                         i, txq[i].we, txq[i].addr, i % 2, ea);
            end
            if (i % 2 == 1) begin
                total++;
                if (txq[i].wdata !== orig[s + 32'(4 * (i / 2))]) begin
                    bad++;
                    $display("FAIL basic_wdata%0d: got %h want %h", i, txq[i].wdata,
                             orig[s + 32'(4 * (i / 2))]);
                end
            end
        end
    endtask

    task automatic test_gnt_delay();
        logic [31:0] s = 32'h8000_0040, d = 32'h8000_0180;
        int len, dc, ec, nd, ne, nb;
        len = $urandom_range(6, 3);
        max_delay = 3;
        stab_err = 0;
        txq.delete();
        exp_mem = mem;
        apply_model(s, d, len);
        do_start(s, d, len);
        observe(400, 0, 0, 0, 0, dc, ec, nd, ne, nb);
        total += 5;
        if (nd !== 1 || ne !== 0) begin bad++; $display("FAIL delay_pulses: got done=%0d err=%0d want 1 0", nd, ne); end
        if (dc < 4 * len + 1) begin bad++; $display("FAIL delay_done_cycle: got %0d want >= %0d", dc, 4 * len + 1); end
        if (stab_err !== 0) begin bad++; $display("FAIL delay_stable: got %0d violations want 0", stab_err); end
        if (txq.size() !== 2 * len) begin bad++; $display("FAIL delay_txn_count: got %0d want %0d", txq.size(), 2 * len); end
        if (mem_diff() !== 0) begin bad++; $display("FAIL delay_mem: got %0d differing words want 0", mem_diff()); end
        max_delay = 0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_len_zero();
        int dc, ec, nd, ne, nb, r0;
        txq.delete();
        r0 = req_seen;
        do_start(32'h8000_0000, 32'h8000_0100, 0);
        observe(20, 0, 0, 0, 0, dc, ec, nd, ne, nb);
        total += 4;
        if (dc !== 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want 1", dc); end
        if (nb !== 1) begin bad++; $display("FAIL zero_busy_cycles: got %0d want 1", nb); end
        if (nd !== 1 || ne !== 0) begin bad++; $display("FAIL zero_pulses: got done=%0d err=%0d want 1 0", nd, ne); end
        if (req_seen - r0 !== 0) begin bad++; $display("FAIL zero_no_req: got %0d req cycles want 0", req_seen - r0); end
    endtask

    task automatic test_illegal();
        int dc, ec, nd, ne, nb;
        txq.delete();
        exp_mem = mem;
        do_start(32'h0000_0000, 32'h8000_0200, 3);
        observe(50, 0, 0, 0, 0, dc, ec, nd, ne, nb);
        total += 6;
        if (ec !== 2) begin bad++; $display("FAIL illegal_err_cycle: got %0d want 2", ec); end
        if (ne !== 1 || nd !== 0) begin bad++; $display("FAIL illegal_pulses: got err=%0d done=%0d want 1 0", ne, nd); end
        if (nb !== 2) begin bad++; $display("FAIL illegal_busy_cycles: got %0d want 2", nb); end
        if (txq.size() !== 0) begin bad++; $display("FAIL illegal_no_txn: got %0d want 0", txq.size()); end
        if (mem_diff() !== 0) begin bad++; $display("FAIL illegal_mem: got %0d differing words want 0", mem_diff()); end
        if (busy_o !== 1'b0 || obi_req_o !== 1'b0) begin
            bad++; $display("FAIL illegal_idle: got busy=%b req=%b want 0 0", busy_o, obi_req_o);
        end
    endtask

    task automatic test_wrap();
        int dc, ec, nd, ne, nb;
        illegal_en = 1'b0;
        txq.delete();
        exp_mem = mem;
        apply_model(32'hFFFF_FFF9, 32'h8000_0301, 4);
        do_start(32'hFFFF_FFF9, 32'h8000_0301, 4);
        observe(100, 0, 0, 0, 0, dc, ec, nd, ne, nb);
        total += 3;
        if (dc !== 17) begin bad++; $display("FAIL wrap_done_cycle: got %0d want 17", dc); end
        if (mem_diff() !== 0) begin bad++; $display("FAIL wrap_mem: got %0d differing words want 0", mem_diff()); end
        if (txq.size() !== 8) begin
            bad++; $display("FAIL wrap_txn_count: got %0d want 8", txq.size());
        end else begin
            total += 3;
            if (txq[0].addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_rd0: got %h want fffffff8", txq[0].addr); end
            if (txq[1].addr !== 32'h8000_0300) begin bad++; $display("FAIL wrap_wr0: got %h want 80000300", txq[1].addr); end
            if (txq[4].addr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_rd2: got %h want 00000000", txq[4].addr); end
        end
        illegal_en = 1'b1;
    endtask

    task automatic test_overlap();
        int dc, ec, nd, ne, nb;
        txq.delete();
        exp_mem = mem;
        apply_model(32'h8000_0000, 32'h8000_0008, 6);
        do_start(32'h8000_0000, 32'h8000_0008, 6);
        observe(100, 0, 0, 0, 0, dc, ec, nd, ne, nb);
        total += 2;
        if (dc !== 25) begin bad++; $display("FAIL overlap_done_cycle: got %0d want 25", dc); end
        if (mem_diff() !== 0) begin bad++; $display("FAIL overlap_mem: got %0d differing words want 0", mem_diff()); end
    endtask

    task automatic test_reset_mid();
        int dc, ec, nd, ne, nb;
        txq.delete();
        do_start(32'h8000_0080, 32'h8000_0280, 4);
        repeat (7) @(negedge clk_i);
        total++;
        if (txq.size() !== 4) begin bad++; $display("FAIL rstmid_txn_before: got %0d want 4", txq.size()); end
        rst_i = 1'b1;
        @(negedge clk_i);
        total += 2;
        if (obi_req_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL rstmid_idle: got req=%b busy=%b want 0 0", obi_req_o, busy_o);
        end
        if (done_o !== 1'b0 || err_o !== 1'b0) begin
            bad++; $display("FAIL rstmid_pulse: got done=%b err=%b want 0 0", done_o, err_o);
        end
        rst_i = 1'b0;
        observe(6, 0, 0, 0, 0, dc, ec, nd, ne, nb);
        total++;
        if (nd !== 0 || ne !== 0 || nb !== 0) begin
            bad++; $display("FAIL rstmid_quiet: got done=%0d err=%0d busy=%0d want 0 0 0", nd, ne, nb);
        end
        txq.delete();
        exp_mem = mem;
        apply_model(32'h8000_00C0, 32'h8000_02C0, 3);
        do_start(32'h8000_00C0, 32'h8000_02C0, 3);
        observe(100, 0, 0, 0, 0, dc, ec, nd, ne, nb);
        total += 2;
        if (dc !== 13) begin bad++; $display("FAIL rstmid_restart_cycle: got %0d want 13", dc); end
        if (mem_diff() !== 0) begin bad++; $display("FAIL rstmid_restart_mem: got %0d differing words want 0", mem_diff()); end
    endtask

    task automatic test_start_busy();
        logic [31:0] s = 32'h8000_0100, d = 32'h8000_0380;
        int dc, ec, nd, ne, nb;
        txq.delete();
        exp_mem = mem;
        apply_model(s, d, 3);
        do_start(s, d, 3);
        observe(100, 5, 32'h8000_0010, 32'h8000_0020, 1, dc, ec, nd, ne, nb);
        total += 4;
        if (dc !== 13) begin bad++; $display("FAIL busy_start_done_cycle: got %0d want 13", dc); end
        if (nd !== 1) begin bad++; $display("FAIL busy_start_pulses: got %0d want 1", nd); end
        if (mem_diff() !== 0) begin bad++; $display("FAIL busy_start_mem: got %0d differing words want 0", mem_diff()); end
        if (txq.size() !== 6) begin
            bad++; $display("FAIL busy_start_txn_count: got %0d want 6", txq.size());
        end else begin
            total++;
            if (txq[4].addr !== s + 32'd8) begin
                bad++; $display("FAIL busy_start_rd2: got %h want %h", txq[4].addr, s + 32'd8);
            end
        end
    endtask

    initial begin
        fill(32'h8000_0000, 256);
        fill(32'hFFFF_FFF8, 4);
        test_reset();
        test_basic_copy();
        test_gnt_delay();
        test_len_zero();
        test_illegal();
        test_wrap();
        test_overlap();
        test_reset_mid();
        test_start_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
